sqrt_checker: RTL and testbench

Sequential squarer and root checker that sits downstream of the square-root unit. It captures a candidate root and the original 16-bit operand, then computes root² with an iterative shift-add datapath. It flags whether the root is the exact floor square root of the operand, i.e. root² ≤ valor < (root+1)². It is used in-system as a self-check and as a checker in the bench.

---
 rtl/sqrt_checker.sv | 123 ++++++++++++
 tb/tb_sqrt_checker.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/sqrt_checker.sv
// Iterative shift-add squarer that checks whether a candidate root is the
// floor square root of a 2*WIDTH_R-bit operand: root^2 <= valor < (root+1)^2.
module sqrt_checker #(
    parameter int WIDTH_R = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start_i,
    input  logic [WIDTH_R-1:0]     root_i,
    input  logic [2*WIDTH_R-1:0]   valor_i,
    output logic                   busy_o,
    output logic                   ready_o,
    output logic [2*WIDTH_R-1:0]   square_o,
    output logic                   ok_o
);

    localparam int W2 = 2 * WIDTH_R;
    localparam int CW = (WIDTH_R > 1) ? $clog2(WIDTH_R) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH_R - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CALC  = 2'd1;
    localparam logic [1:0] ST_CHECK = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]         state_r;
    logic [W2-1:0]      mcand_r;
    logic [WIDTH_R-1:0] mplier_r;
    logic [WIDTH_R-1:0] root_r;
    logic [W2-1:0]      opnd_r;
    logic [W2-1:0]      acc_r;
    logic [CW-1:0]      cnt_r;
    logic               busy_r;
    logic               ready_r;
    logic [W2-1:0]      square_r;
    logic               ok_r;

    logic               accept_s;
    logic [W2-1:0]      add_s;
    logic [W2:0]        nxt_s;
    logic               ok_s;

    // Start acceptance, partial-product add and the floor-root bound test.
    // nxt is one bit wider so (2^W)^2 = (root+1)^2 for root = 2^W-1 is exact.
    always_comb begin
        accept_s = 1'b0;
        add_s    = acc_r;
        nxt_s    = {1'b0, acc_r} + {{WIDTH_R{1'b0}}, root_r, 1'b1};
        ok_s     = 1'b0;
        if ((state_r == ST_IDLE) || (state_r == ST_DONE)) begin
            accept_s = start_i;
        end else begin
            accept_s = 1'b0;
        end
        if (mplier_r[0]) begin
            add_s = acc_r + mcand_r;
        end else begin
            add_s = acc_r;
        end
        ok_s = (acc_r <= opnd_r) && ({1'b0, opnd_r} < nxt_s);
    end

    // Control FSM and datapath registers; outputs are registered copies.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            mcand_r  <= '0;
            mplier_r <= '0;
            root_r   <= '0;
            opnd_r   <= '0;
            acc_r    <= '0;
            cnt_r    <= '0;
            busy_r   <= 1'b0;
            ready_r  <= 1'b0;
            square_r <= '0;
            ok_r     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (accept_s) begin
                        mcand_r  <= {{WIDTH_R{1'b0}}, root_i};
                        mplier_r <= root_i;
                        root_r   <= root_i;
                        opnd_r   <= valor_i;
                        acc_r    <= '0;
                        cnt_r    <= '0;
                        busy_r   <= 1'b1;
                        ready_r  <= 1'b0;
                        state_r  <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    acc_r    <= add_s;
                    mcand_r  <= mcand_r << 1;
                    mplier_r <= mplier_r >> 1;
                    cnt_r    <= cnt_r + CNT_ONE;
                    if (cnt_r == CNT_LAST) begin
                        state_r <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    square_r <= acc_r;
                    ok_r     <= ok_s;
                    busy_r   <= 1'b0;
                    ready_r  <= 1'b1;
                    state_r  <= ST_DONE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    ready_r <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy_o   = busy_r;
    assign ready_o  = ready_r;
    assign square_o = square_r;
    assign ok_o     = ok_r;

endmodule

// File: tb/tb_sqrt_checker.sv
// Scoreboard bench for sqrt_checker: stimulus pushes expected results, a
// monitor pops and compares them on every rising edge of ready_o.
module tb_sqrt_checker;

    typedef struct packed {
        logic [15:0] sq;
        logic        ok;
        logic [7:0]  id;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        start_i;
    logic [7:0]  root_i;
    logic [15:0] valor_i;
    logic        busy_o;
    logic        ready_o;
    logic [15:0] square_o;
    logic        ok_o;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    logic ready_prev = 1'b0;

    sqrt_checker #(.WIDTH_R(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (start_i),
        .root_i   (root_i),
        .valor_i  (valor_i),
        .busy_o   (busy_o),
        .ready_o  (ready_o),
        .square_o (square_o),
        .ok_o     (ok_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Monitor: compare each new result against the scoreboard head.
    always @(negedge clk) begin
        if (rst_n) begin
            check("busy_ready_exclusive", int'(busy_o && ready_o), 0);
        end
        if (ready_o && !ready_prev) begin
            if (sb.size() == 0) begin
                check("unexpected_result", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check($sformatf("square_id%0d", e.id), int'(square_o), int'(e.sq));
                check($sformatf("ok_id%0d", e.id), int'(ok_o), int'(e.ok));
            end
        end
        ready_prev = ready_o;
    end

    // Issue one check, wait for ready; optionally inject an ignored start.
    task automatic run_check(input logic [7:0] r, input logic [15:0] v,
                             input logic [15:0] esq, input logic eok,
                             input logic [7:0] id, input bit inj,
                             output int edges, output int busy_cnt);
        exp_t e;
        e.sq = esq; e.ok = eok; e.id = id;
        sb.push_back(e);
        @(negedge clk);
        root_i = r; valor_i = v; start_i = 1'b1;
        @(posedge clk);
        edges = 1;
        busy_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            start_i = 1'b0;
            if (busy_o) busy_cnt++;
            if (ready_o) break;
            if (inj && edges == 4) begin
                start_i = 1'b1; root_i = 8'd3; valor_i = 16'd9;
            end
            @(posedge clk);
            edges++;
        end
        start_i = 1'b0;
        if (!ready_o) check("ready_timeout", 0, 1);
    endtask

    int edges, busy_cnt, n_ready, gap, t_first;

    initial begin
        rst_n = 1'b0; start_i = 1'b0; root_i = 8'd0; valor_i = 16'd0;
        repeat (2) @(negedge clk);
        check("rst_busy", int'(busy_o), 0);
        check("rst_ready", int'(ready_o), 0);
        check("rst_square", int'(square_o), 0);
        check("rst_ok", int'(ok_o), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_check(8'd16, 16'd256, 16'd256, 1'b1, 8'd1, 1'b0, edges, busy_cnt);
        check("latency_edges", edges, 10);
        check("busy_cycles", busy_cnt, 9);
        repeat (3) @(negedge clk);
        check("hold_square", int'(square_o), 256);
        check("hold_ready", int'(ready_o), 1);

        run_check(8'd15, 16'd255, 16'd225, 1'b1, 8'd2, 1'b0, edges, busy_cnt);
        run_check(8'd16, 16'd255, 16'd256, 1'b0, 8'd3, 1'b0, edges, busy_cnt);
        run_check(8'd255, 16'd65535, 16'd65025, 1'b1, 8'd4, 1'b0, edges, busy_cnt);
        run_check(8'd254, 16'd65535, 16'd64516, 1'b0, 8'd5, 1'b0, edges, busy_cnt);
        run_check(8'd0, 16'd0, 16'd0, 1'b1, 8'd6, 1'b0, edges, busy_cnt);
        run_check(8'd0, 16'd1, 16'd0, 1'b0, 8'd7, 1'b0, edges, busy_cnt);
        run_check(8'd12, 16'd150, 16'd144, 1'b1, 8'd8, 1'b1, edges, busy_cnt);
        check("ignored_start_latency", edges, 10);

        // Back-to-back: start held high in DONE gives two results 10 edges apart.
        sb.push_back('{sq: 16'd25, ok: 1'b1, id: 8'd9});
        sb.push_back('{sq: 16'd25, ok: 1'b1, id: 8'd10});
        @(negedge clk);
        root_i = 8'd5; valor_i = 16'd30; start_i = 1'b1;
        n_ready = 0; gap = 0; t_first = 0;
        for (int i = 1; i < 60; i++) begin
            @(negedge clk);
            if (ready_o) begin
                n_ready++;
                if (n_ready == 1) t_first = i;
                if (n_ready == 2) begin
                    gap = i - t_first;
                    start_i = 1'b0;
                    break;
                end
            end
        end
        start_i = 1'b0;
        check("b2b_results", n_ready, 2);
        check("b2b_gap", gap, 10);

        // Abort mid-calculation with an asynchronous reset.
        @(negedge clk);
        root_i = 8'd200; valor_i = 16'd40000; start_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_i = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_busy", int'(busy_o), 0);
        check("abort_ready", int'(ready_o), 0);
        check("abort_square", int'(square_o), 0);
        check("abort_ok", int'(ok_o), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_check(8'd7, 16'd63, 16'd49, 1'b1, 8'd11, 1'b0, edges, busy_cnt);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
